instr_fetch_unit: RTL and testbench

//  Instruction fetch stage directly upstream of the 8K x 8 unified Memory (combinational read, 13-bit address).
//  - Holds the PC and reads one or two consecutive bytes.
//  - Assembles them into a 16-bit instruction word and hands it to the control FSM over a valid/ready handshake.
//  - Drives mem_addr only while fetch_active=1. The datapath address mux uses fetch_active as its select.

---
 rtl/instr_fetch_unit_if.sv | 29 ++
 rtl/instr_fetch_unit.sv | 99 +++++++++
 tb/tb_instr_fetch_unit.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus: memory read port, PC load, and the instruction valid/ready handshake.
// master = fetch unit side, slave = memory/controller side.
interface instr_fetch_unit_if #(
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned DATA_W = 8
);
  logic                  fetch_req;
  logic                  pc_load;
  logic [ADDR_W-1:0]     pc_load_val;
  logic [DATA_W-1:0]     mem_rdata;
  logic [ADDR_W-1:0]     mem_addr;
  logic                  fetch_active;
  logic [2*DATA_W-1:0]   instr;
  logic                  instr_len;
  logic [ADDR_W-1:0]     instr_pc;
  logic                  instr_valid;
  logic                  instr_ready;
  logic [ADDR_W-1:0]     pc;

  modport master (
    input  fetch_req, pc_load, pc_load_val, mem_rdata, instr_ready,
    output mem_addr, fetch_active, instr, instr_len, instr_pc, instr_valid, pc
  );

  modport slave (
    output fetch_req, pc_load, pc_load_val, mem_rdata, instr_ready,
    input  mem_addr, fetch_active, instr, instr_len, instr_pc, instr_valid, pc
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: reads one or two bytes at the PC from a combinational-read memory
// and presents the assembled 16-bit instruction over a valid/ready handshake.
module instr_fetch_unit #(
  parameter int unsigned       ADDR_W   = 13,
  parameter int unsigned       DATA_W   = 8,
  parameter logic [2:0]        SHORT_OP = 3'b100,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic               clk,
  input logic               rst,
  instr_fetch_unit_if.master bus
);

  typedef enum logic [1:0] {StIdle, StFetch1, StFetch2, StValid} state_e;

  state_e              state;
  logic [ADDR_W-1:0]   pc_q;
  logic [ADDR_W-1:0]   pc_inc;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic                fetch_active_q;
  logic [2*DATA_W-1:0] instr_q;
  logic                instr_len_q;
  logic [ADDR_W-1:0]   instr_pc_q;
  logic                instr_valid_q;

  // Natural overflow gives the modulo-2^ADDR_W wrap.
  assign pc_inc = pc_q + ADDR_W'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= StIdle;
      pc_q           <= RESET_PC;
      mem_addr_q     <= '0;
      fetch_active_q <= 1'b0;
      instr_q        <= '0;
      instr_len_q    <= 1'b0;
      instr_pc_q     <= '0;
      instr_valid_q  <= 1'b0;
    end else if (bus.pc_load) begin
      // Jump abandons any fetch; an instruction handshaking this cycle still counts as taken.
      pc_q           <= bus.pc_load_val;
      state          <= StIdle;
      mem_addr_q     <= '0;
      fetch_active_q <= 1'b0;
      instr_valid_q  <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          if (bus.fetch_req) begin
            state          <= StFetch1;
            mem_addr_q     <= pc_q;
            fetch_active_q <= 1'b1;
          end
        end
        StFetch1: begin
          instr_q[2*DATA_W-1:DATA_W] <= bus.mem_rdata;
          instr_pc_q                 <= pc_q;
          pc_q                       <= pc_inc;
          if (bus.mem_rdata[DATA_W-1 -: 3] == SHORT_OP) begin
            instr_q[DATA_W-1:0] <= '0;
            instr_len_q         <= 1'b0;
            instr_valid_q       <= 1'b1;
            fetch_active_q      <= 1'b0;
            mem_addr_q          <= '0;
            state               <= StValid;
          end else begin
            mem_addr_q <= pc_inc;
            state      <= StFetch2;
          end
        end
        StFetch2: begin
          instr_q[DATA_W-1:0] <= bus.mem_rdata;
          instr_len_q         <= 1'b1;
          pc_q                <= pc_inc;
          instr_valid_q       <= 1'b1;
          fetch_active_q      <= 1'b0;
          mem_addr_q          <= '0;
          state               <= StValid;
        end
        StValid: begin
          if (bus.instr_ready) begin
            instr_valid_q <= 1'b0;
            state         <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  assign bus.pc           = pc_q;
  assign bus.mem_addr     = mem_addr_q;
  assign bus.fetch_active = fetch_active_q;
  assign bus.instr        = instr_q;
  assign bus.instr_len    = instr_len_q;
  assign bus.instr_pc     = instr_pc_q;
  assign bus.instr_valid  = instr_valid_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized scoreboard bench for instr_fetch_unit with a byte-level memory model.
module tb_instr_fetch_unit;

  typedef struct packed {
    logic [15:0] instr;
    logic        len;
    logic [12:0] pc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [7:0] mem [8192];
  exp_t exp_q [$];
  int total = 0;
  int bad = 0;
  int mpc = 0;

  instr_fetch_unit_if #(.ADDR_W(13), .DATA_W(8)) bus ();

  instr_fetch_unit #(
    .ADDR_W(13), .DATA_W(8), .SHORT_OP(3'b100), .RESET_PC(13'd0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  assign bus.mem_rdata = mem[bus.mem_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, want, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: the handshake completes on the posedge following this negedge.
  always @(negedge clk) begin
    exp_t e;
    if (rst && !bus.fetch_active) check("idle_mem_addr", 32'(bus.mem_addr), 32'd0);
    if (rst && bus.instr_valid && bus.instr_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL accept_unexpected: got instr %0h want none", bus.instr);
      end else begin
        e = exp_q.pop_front();
        check("sb_instr", 32'(bus.instr), 32'(e.instr));
        check("sb_len", 32'(bus.instr_len), 32'(e.len));
        check("sb_instr_pc", 32'(bus.instr_pc), 32'(e.pc));
      end
    end
  end

  function automatic exp_t model(input int p);
    exp_t e;
    logic [7:0] b0;
    b0 = mem[p];
    e.pc = 13'(p);
    if (b0[7:5] == 3'b100) begin
      e.instr = {b0, 8'h00};
      e.len   = 1'b0;
    end else begin
      e.instr = {b0, mem[(p + 1) % 8192]};
      e.len   = 1'b1;
    end
    return e;
  endfunction

  task automatic do_load(input int v);
    bus.pc_load = 1'b1;
    bus.pc_load_val = 13'(v);
    step();
    bus.pc_load = 1'b0;
    check("load_pc", 32'(bus.pc), 32'(v));
    check("load_idle", 32'(bus.fetch_active), 32'd0);
    mpc = v;
  endtask

  // Runs one fetch up to VALID; leaves the instruction presented.
  task automatic fetch_to_valid(input int want, output exp_t e, output int npc);
    int p;
    int n;
    p = mpc;
    e = model(p);
    npc = (p + (e.len ? 2 : 1)) % 8192;
    exp_q.push_back(e);
    bus.fetch_req = 1'b1;
    step();
    bus.fetch_req = 1'b0;
    n = 1;
    check("fetch_active", 32'(bus.fetch_active), 32'd1);
    check("fetch_addr", 32'(bus.mem_addr), 32'(p));
    while (!bus.instr_valid && n < 8) begin
      step();
      n++;
    end
    check("latency", 32'(n), e.len ? 32'd3 : 32'd2);
    if (want >= 0) check("directed_instr", 32'(bus.instr), 32'(want));
  endtask

  task automatic do_fetch(input int stall, input int want);
    exp_t e;
    int npc;
    fetch_to_valid(want, e, npc);
    for (int i = 0; i < stall; i++) begin
      step();
      check("hold_valid", 32'(bus.instr_valid), 32'd1);
      check("hold_instr", 32'(bus.instr), 32'(e.instr));
      check("hold_pc", 32'(bus.pc), 32'(npc));
    end
    check("pc_after", 32'(bus.pc), 32'(npc));
    bus.instr_ready = 1'b1;
    step();
    bus.instr_ready = 1'b0;
    check("drop_valid", 32'(bus.instr_valid), 32'd0);
    mpc = npc;
  endtask

  // pc_load during FETCH1 (at=1) or FETCH2 (at=2, two-byte only).
  task automatic do_abort(input int at, input int v);
    bus.fetch_req = 1'b1;
    step();
    bus.fetch_req = 1'b0;
    if (at == 2) step();
    bus.pc_load = 1'b1;
    bus.pc_load_val = 13'(v);
    step();
    bus.pc_load = 1'b0;
    check("abort_pc", 32'(bus.pc), 32'(v));
    check("abort_fa", 32'(bus.fetch_active), 32'd0);
    for (int i = 0; i < 3; i++) begin
      check("abort_no_valid", 32'(bus.instr_valid), 32'd0);
      step();
    end
    mpc = v;
  endtask

  task automatic do_load_accept(input int v);
    exp_t e;
    int npc;
    fetch_to_valid(-1, e, npc);
    bus.pc_load = 1'b1;
    bus.pc_load_val = 13'(v);
    bus.instr_ready = 1'b1;
    step();
    bus.pc_load = 1'b0;
    bus.instr_ready = 1'b0;
    check("ldacc_valid", 32'(bus.instr_valid), 32'd0);
    check("ldacc_pc", 32'(bus.pc), 32'(v));
    mpc = v;
  endtask

  task automatic check_reset_state();
    check("rst_pc", 32'(bus.pc), 32'd0);
    check("rst_instr", 32'(bus.instr), 32'd0);
    check("rst_instr_pc", 32'(bus.instr_pc), 32'd0);
    check("rst_len", 32'(bus.instr_len), 32'd0);
    check("rst_valid", 32'(bus.instr_valid), 32'd0);
    check("rst_fa", 32'(bus.fetch_active), 32'd0);
    check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    int op;
    for (int i = 0; i < 8192; i++) mem[i] = 8'($urandom);
    mem[0] = 8'hE0;
    mem[1] = 8'h43;
    mem[3] = 8'h99;
    mem[30] = 8'h99;
    mem[8191] = 8'h20;
    bus.fetch_req = 1'b0;
    bus.pc_load = 1'b0;
    bus.pc_load_val = '0;
    bus.instr_ready = 1'b0;

    repeat (3) step();
    check_reset_state();
    rst = 1'b1;
    step();

    do_fetch(0, 16'hE043);          // two-byte at 0
    do_load(3);
    do_fetch(0, 16'h9900);          // one-byte at 3
    do_fetch(5, -1);                // backpressure
    do_load(8191);
    do_fetch(0, 16'h20E0);          // wrap
    check("wrap_pc", 32'(bus.pc), 32'd1);
    do_load(0);
    do_abort(2, 30);
    do_fetch(1, 16'h9900);

    // Asynchronous reset mid-FETCH2
    do_load(0);
    bus.fetch_req = 1'b1;
    step();
    bus.fetch_req = 1'b0;
    step();
    #2;
    rst = 1'b0;
    #1;
    check_reset_state();
    step();
    rst = 1'b1;
    mpc = 0;
    step();
    do_fetch(0, 16'hE043);
    check("rerun_pc", 32'(bus.pc), 32'd2);

    for (int k = 0; k < 200; k++) begin
      op = int'($urandom_range(0, 9));
      if (op <= 4) begin
        do_fetch(int'($urandom_range(0, 3)), -1);
      end else if (op == 5) begin
        do_load(($urandom_range(0, 3) == 0) ? 8191 : int'($urandom_range(0, 8191)));
      end else if (op == 6) begin
        b = mem[mpc];
        do_abort((b[7:5] != 3'b100 && $urandom_range(0, 1) == 1) ? 2 : 1,
                 int'($urandom_range(0, 8191)));
      end else if (op == 7) begin
        do_load_accept(int'($urandom_range(0, 8191)));
      end else if (op == 8) begin
        // pc_load beats a simultaneous fetch_req
        bus.pc_load = 1'b1;
        bus.fetch_req = 1'b1;
        bus.pc_load_val = 13'($urandom_range(0, 8191));
        mpc = int'(bus.pc_load_val);
        step();
        bus.pc_load = 1'b0;
        bus.fetch_req = 1'b0;
        step();
        check("ld_fr_fa", 32'(bus.fetch_active), 32'd0);
        check("ld_fr_pc", 32'(bus.pc), 32'(mpc));
      end else begin
        // ready while idle is ignored
        bus.instr_ready = 1'b1;
        repeat (2) step();
        bus.instr_ready = 1'b0;
        check("idle_ready_valid", 32'(bus.instr_valid), 32'd0);
        check("idle_ready_pc", 32'(bus.pc), 32'(mpc));
      end
    end

    repeat (3) step();
    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
